// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// data-memory wait handling with a timeout into a sticky error state.
module hazard_ctrl #(
  parameter int AWIDTH  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              h_clk,
  input  logic              h_rst,
  input  logic              h_i_id_valid,
  input  logic [AWIDTH-1:0] h_i_id_rs,
  input  logic [AWIDTH-1:0] h_i_id_rt,
  input  logic              h_i_id_uses_rt,
  input  logic              h_i_ex_valid,
  input  logic              h_i_ex_memread,
  input  logic [AWIDTH-1:0] h_i_ex_rt,
  input  logic              h_i_branch_taken,
  input  logic              h_i_mem_req,
  input  logic              h_i_mem_ready,
  output logic              h_o_pc_en,
  output logic              h_o_ifid_en,
  output logic              h_o_idex_en,
  output logic              h_o_exmem_en,
  output logic              h_o_ifid_flush,
  output logic              h_o_idex_bubble,
  output logic [1:0]        h_o_state,
  output logic [15:0]       h_o_stall_cnt,
  output logic [15:0]       h_o_flush_cnt,
  output logic              h_o_mem_err
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2,
    ERR    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;
  logic        err_q, err_d;

  logic load_use_s, mem_busy_s, run_path_s;
  logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, flush_s, bubble_s;

  assign load_use_s = h_i_id_valid & h_i_ex_valid & h_i_ex_memread &
                      (h_i_ex_rt != {AWIDTH{1'b0}}) &
                      ((h_i_ex_rt == h_i_id_rs) | (h_i_id_uses_rt & (h_i_ex_rt == h_i_id_rt)));
  assign mem_busy_s = h_i_mem_req & ~h_i_mem_ready;

  // Next-state and zero-latency enable decode; MWAIT with ready falls into the RUN decode.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    run_path_s = 1'b0;
    pc_en_s    = 1'b0;
    ifid_en_s  = 1'b0;
    idex_en_s  = 1'b0;
    exmem_en_s = 1'b0;
    flush_s    = 1'b0;
    bubble_s   = 1'b0;
    case (state_q)
      RUN, LSTALL: run_path_s = 1'b1;
      MWAIT: begin
        if (!h_i_mem_ready) begin
          if (wait_q == 8'(TIMEOUT)) begin
            state_d = ERR;
            err_d   = 1'b1;
            wait_d  = 8'd0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          run_path_s = 1'b1;
          wait_d     = 8'd0;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase

    if (run_path_s) begin
      if (mem_busy_s && (state_q != MWAIT)) begin
        state_d = MWAIT;
        wait_d  = 8'd1;
      end else if (h_i_branch_taken) begin
        {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b1111;
        flush_s  = 1'b1;
        bubble_s = 1'b1;
        state_d  = RUN;
      end else if (load_use_s && (state_q != LSTALL)) begin
        {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b0011;
        bubble_s = 1'b1;
        state_d  = LSTALL;
      end else begin
        {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b1111;
        state_d = RUN;
      end
    end else begin
      {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b0000;
    end
  end

  // Saturating event counters; ERR cycles are not counted as stalls.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en_s && (state_q != ERR) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
    if (flush_s && (flush_q != 16'hFFFF)) begin
      flush_d = flush_q + 16'd1;
    end else begin
      flush_d = flush_q;
    end
  end

  // State, wait counter, statistics and sticky error registers.
  always_ff @(posedge h_clk or negedge h_rst) begin
    if (!h_rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  assign h_o_pc_en       = h_rst & pc_en_s;
  assign h_o_ifid_en     = h_rst & ifid_en_s;
  assign h_o_idex_en     = h_rst & idex_en_s;
  assign h_o_exmem_en    = h_rst & exmem_en_s;
  assign h_o_ifid_flush  = h_rst & flush_s;
  assign h_o_idex_bubble = h_rst & bubble_s;
  assign h_o_state       = state_q;
  assign h_o_stall_cnt   = stall_q;
  assign h_o_flush_cnt   = flush_q;
  assign h_o_mem_err     = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl plus hand sequences for memory wait, timeout and reset.
module tb_hazard_ctrl;

  localparam int AW = 5;

  logic          h_clk = 1'b0;
  logic          h_rst;
  logic          id_valid, id_uses_rt, ex_valid, ex_memread, branch_taken, mem_req, mem_ready;
  logic [AW-1:0] id_rs, id_rt, ex_rt;
  logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, mem_err;
  logic [1:0]    state;
  logic [15:0]   stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.AWIDTH(AW), .TIMEOUT(4)) dut (
    .h_clk(h_clk), .h_rst(h_rst),
    .h_i_id_valid(id_valid), .h_i_id_rs(id_rs), .h_i_id_rt(id_rt), .h_i_id_uses_rt(id_uses_rt),
    .h_i_ex_valid(ex_valid), .h_i_ex_memread(ex_memread), .h_i_ex_rt(ex_rt),
    .h_i_branch_taken(branch_taken), .h_i_mem_req(mem_req), .h_i_mem_ready(mem_ready),
    .h_o_pc_en(pc_en), .h_o_ifid_en(ifid_en), .h_o_idex_en(idex_en), .h_o_exmem_en(exmem_en),
    .h_o_ifid_flush(ifid_flush), .h_o_idex_bubble(idex_bubble), .h_o_state(state),
    .h_o_stall_cnt(stall_cnt), .h_o_flush_cnt(flush_cnt), .h_o_mem_err(mem_err)
  );

  always #5 h_clk = ~h_clk;

  typedef struct {
    logic          idv;
    logic [AW-1:0] rs, rt;
    logic          urt, exv, exmr;
    logic [AW-1:0] ext;
    logic          br, mreq, mrdy;
    logic [3:0]    en;
    logic          fl, bb;
    logic [1:0]    st;
    logic [15:0]   stall, flc;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic idv, input int rs, input int rt, input logic urt,
                              input logic exv, input logic exmr, input int ext, input logic br,
                              input logic mreq, input logic mrdy, input logic [3:0] en,
                              input logic fl, input logic bb, input logic [1:0] st,
                              input int stall, input int flc);
    vec_t v;
    v.idv = idv; v.rs = AW'(rs); v.rt = AW'(rt); v.urt = urt; v.exv = exv; v.exmr = exmr;
    v.ext = AW'(ext); v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.en = en; v.fl = fl; v.bb = bb;
    v.st = st; v.stall = 16'(stall); v.flc = 16'(flc);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_rt = '0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  function automatic logic [3:0] ens();
    return {pc_en, ifid_en, idex_en, exmem_en};
  endfunction

  // Async reset pulse, checking forced outputs while asserted.
  task automatic do_reset(input string tag);
    @(negedge h_clk);
    h_rst = 1'b0;
    #1;
    check({tag, "_rst_en"}, {28'd0, ens()}, 32'h0);
    check({tag, "_rst_flbb"}, {30'd0, ifid_flush, idex_bubble}, 32'h0);
    check({tag, "_rst_state"}, {30'd0, state}, 32'd0);
    check({tag, "_rst_cnt"}, {stall_cnt, flush_cnt}, 32'h0);
    check({tag, "_rst_err"}, {31'd0, mem_err}, 32'd0);
    @(negedge h_clk);
    h_rst = 1'b1;
  endtask

  // Memory busy from RUN with TIMEOUT=4: 5 frozen cycles then ERR.
  task automatic timeout_seq(input string tag);
    for (int c = 1; c <= 5; c++) begin
      @(negedge h_clk);
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      check($sformatf("%s_to_en%0d", tag, c), {28'd0, ens()}, 32'h0);
      @(posedge h_clk);
      #1;
      check($sformatf("%s_to_st%0d", tag, c), {30'd0, state}, (c == 5) ? 32'd3 : 32'd2);
      check($sformatf("%s_to_err%0d", tag, c), {31'd0, mem_err}, (c == 5) ? 32'd1 : 32'd0);
    end
    check({tag, "_to_stall"}, {16'd0, stall_cnt}, 32'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(0,0,0,0, 0,0,0, 0,0,0, 4'b1111,0,0, 2'd0, 0,0);
    vecs[1]  = mk(1,5,0,0, 1,1,5, 0,0,0, 4'b0011,0,1, 2'd1, 1,0);
    vecs[2]  = mk(1,5,0,0, 1,1,5, 0,0,0, 4'b1111,0,0, 2'd0, 1,0);
    vecs[3]  = mk(1,0,0,0, 1,1,0, 0,0,0, 4'b1111,0,0, 2'd0, 1,0);
    vecs[4]  = mk(1,3,7,1, 1,1,7, 0,0,0, 4'b0011,0,1, 2'd1, 2,0);
    vecs[5]  = mk(1,3,7,1, 1,1,7, 1,0,0, 4'b1111,1,1, 2'd0, 2,1);
    vecs[6]  = mk(1,3,7,0, 1,1,7, 0,0,0, 4'b1111,0,0, 2'd0, 2,1);
    vecs[7]  = mk(1,7,0,0, 0,1,7, 0,0,0, 4'b1111,0,0, 2'd0, 2,1);
    vecs[8]  = mk(1,7,0,0, 1,0,7, 0,0,0, 4'b1111,0,0, 2'd0, 2,1);
    vecs[9]  = mk(1,9,0,0, 1,1,9, 1,0,0, 4'b1111,1,1, 2'd0, 2,2);
    vecs[10] = mk(1,9,0,0, 1,1,9, 1,1,0, 4'b0000,0,0, 2'd2, 3,2);
    vecs[11] = mk(1,9,0,0, 1,1,9, 0,1,1, 4'b0011,0,1, 2'd1, 4,2);
    vecs[12] = mk(1,9,0,0, 1,1,9, 0,1,0, 4'b0000,0,0, 2'd2, 5,2);
    vecs[13] = mk(0,0,0,0, 0,0,0, 0,1,0, 4'b0000,0,0, 2'd2, 6,2);
    vecs[14] = mk(0,0,0,0, 0,0,0, 1,1,1, 4'b1111,1,1, 2'd0, 6,3);
    vecs[15] = mk(0,0,0,0, 0,0,0, 0,1,1, 4'b1111,0,0, 2'd0, 6,3);
    vecs[16] = mk(0,5,0,0, 1,1,5, 0,0,0, 4'b1111,0,0, 2'd0, 6,3);

    drive_idle();
    h_rst = 1'b1;
    do_reset("init");

    for (int i = 0; i < 17; i++) begin
      @(negedge h_clk);
      id_valid = vecs[i].idv; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].urt;
      ex_valid = vecs[i].exv; ex_memread = vecs[i].exmr; ex_rt = vecs[i].ext;
      branch_taken = vecs[i].br; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      #1;
      check($sformatf("v%0d_en", i), {28'd0, ens()}, {28'd0, vecs[i].en});
      check($sformatf("v%0d_flbb", i), {30'd0, ifid_flush, idex_bubble}, {30'd0, vecs[i].fl, vecs[i].bb});
      @(posedge h_clk);
      #1;
      check($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, vecs[i].st});
      check($sformatf("v%0d_cnts", i), {stall_cnt, flush_cnt}, {vecs[i].stall, vecs[i].flc});
    end

    // Three busy cycles then ready.
    drive_idle();
    do_reset("mw");
    for (int c = 1; c <= 3; c++) begin
      @(negedge h_clk);
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      check($sformatf("mw_en%0d", c), {28'd0, ens()}, 32'h0);
      @(posedge h_clk);
      #1;
      check($sformatf("mw_st%0d", c), {30'd0, state}, 32'd2);
    end
    @(negedge h_clk);
    mem_ready = 1'b1;
    #1;
    check("mw_ready_en", {28'd0, ens()}, 32'hF);
    @(posedge h_clk);
    #1;
    check("mw_ready_st", {30'd0, state}, 32'd0);
    check("mw_stall", {16'd0, stall_cnt}, 32'd3);

    // Timeout into ERR, ERR holds, reset recovers.
    drive_idle();
    do_reset("to");
    timeout_seq("a");
    for (int c = 0; c < 3; c++) begin
      @(negedge h_clk);
      mem_ready = 1'b1; branch_taken = 1'b1;
      #1;
      check($sformatf("err_en%0d", c), {26'd0, ens(), ifid_flush, idex_bubble}, 32'h0);
      @(posedge h_clk);
      #1;
      check($sformatf("err_st%0d", c), {30'd0, state}, 32'd3);
    end
    check("err_cnts", {stall_cnt, flush_cnt}, {16'd5, 16'd0});
    drive_idle();
    do_reset("err");
    @(negedge h_clk);
    #1;
    check("post_err_en", {28'd0, ens()}, 32'hF);
    check("post_err_state", {30'd0, state}, 32'd0);

    // Reset mid-MWAIT must clear the wait counter.
    for (int c = 0; c < 3; c++) begin
      @(negedge h_clk);
      mem_req = 1'b1; mem_ready = 1'b0;
    end
    @(posedge h_clk);
    #1;
    check("midwait_state", {30'd0, state}, 32'd2);
    drive_idle();
    do_reset("mid");
    timeout_seq("b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
